// File: rtl/prog_counter_core.sv
// Programmable event counter: prescaler, terminal value and four counting modes,
// configured through a small byte-wide register port.
module prog_counter_core #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_PING    = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0]   CNT_ONE  = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic               run_q, run_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               tc_q, tc_d;
  logic               tick;
  logic [15:0]        limit_ext;

  // Register readback; LIMIT is zero-extended so bits at or above WIDTH read 0.
  always_comb begin
    limit_ext = 16'(limit_q);
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = {5'b0, run_q, mode_q};
      2'd1:    cfg_rdata = 8'(presc_q);
      2'd2:    cfg_rdata = limit_ext[7:0];
      default: cfg_rdata = limit_ext[15:8];
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    run_d   = run_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    limit_d = limit_q;
    count_d = count_q;
    tc_d    = 1'b0;

    tick = run_q && ena && (pcnt_q == presc_q);

    if (!run_q) begin
      pcnt_d = '0;
    end else if (ena) begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_ONE;
    end

    // Compares use >= / > so a LIMIT lowered below the count recovers on the next tick.
    if (tick) begin
      case (mode_q)
        MODE_UP: begin
          if (count_q >= limit_q) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        MODE_DOWN: begin
          if (count_q == '0 || count_q > limit_q) begin
            count_d = limit_q;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            if (count_q >= limit_q) begin
              dir_d   = DIR_DOWN;
              count_d = (limit_q == '0) ? '0 : limit_q - CNT_ONE;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else begin
            if (count_q == '0) begin
              dir_d   = DIR_UP;
              count_d = (limit_q == '0) ? '0 : CNT_ONE;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        default: begin
          if (count_q >= limit_q || count_q == limit_q - CNT_ONE) begin
            count_d = limit_q;
            tc_d    = 1'b1;
            run_d   = 1'b0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      endcase
    end

    // Config writes are applied last so they override tick side effects (clr beats a tick).
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          mode_d = mode_e'(cfg_wdata[1:0]);
          run_d  = cfg_wdata[2];
          dir_d  = DIR_UP;
          if (cfg_wdata[3]) begin
            count_d = (mode_e'(cfg_wdata[1:0]) == MODE_DOWN) ? limit_q : '0;
            pcnt_d  = '0;
            tc_d    = 1'b0;
          end
        end
        2'd1:    presc_d = cfg_wdata[PRESC_W-1:0];
        default: ;
      endcase
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (cfg_we && cfg_addr == ((i < 8) ? 2'd2 : 2'd3)) begin
        limit_d[i] = cfg_wdata[i % 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_UP;
      dir_q   <= DIR_UP;
      run_q   <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
      limit_q <= '1;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      limit_q <= limit_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = run_q;

endmodule

// File: doc/prog_counter_core.md
Name: prog_counter_core

Overview:
- Parametrised, software-configurable event counter. Successor to the fixed 8-bit free-running blink counter.
- Adds a programmable prescaler, a programmable terminal value and four counting modes: up-wrap, down-wrap, ping-pong and one-shot.
- Adds a registered terminal-count pulse and a small byte-wide config port.
- Sits behind the tile's user pins: config arrives from ui_in/uio_in, count drives uo_out.

Parameters:
- WIDTH, 8, counter and LIMIT width in bits; legal range 2..16.
- PRESC_W, 8, prescaler width in bits; legal range 1..8.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  tile enable; low freezes prescaler, count and dir
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_addr  in  2  register select
- cfg_wdata  in  8  write data
- cfg_rdata  out  8  combinational readback of the selected register
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, one cycle wide
- running  out  1  equals CTRL.run

Behaviour:
- Register map:
  - addr0 CTRL: [1:0] mode (0 up-wrap, 1 down-wrap, 2 ping-pong, 3 one-shot up); [2] run; [3] clr, a write-1 command that reads 0; [7:4] read 0.
  - addr1 PRESCALE: low PRESC_W bits used; unused bits read 0.
  - addr2 LIMIT[7:0].
  - addr3 LIMIT[15:8]: bits at or above WIDTH are ignored and read 0.
- Reset (rst_n low at clk edge):
  - count=0, tc=0, mode=0, run=0, PRESCALE=0, LIMIT=all ones, dir=up, prescaler counter=0.
  - Applies mid-operation; a config write in the same cycle is discarded.
- Prescaler:
  - While run=1 and ena=1, pcnt increments each cycle.
  - When pcnt==PRESCALE, tick=1 and pcnt returns to 0. PRESCALE=0 gives a tick every cycle.
  - run=0 holds pcnt at 0.
- Count update on tick (count and tc register on the same edge; tc=0 on all non-tick cycles):
  - Up-wrap: if count>=LIMIT then count<=0 and tc=1, else count+1.
  - Down-wrap: if count==0 or count>LIMIT then count<=LIMIT and tc=1, else count-1.
  - Ping-pong, dir up: if count>=LIMIT then dir<=down, count<=LIMIT-1 (0 if LIMIT==0), tc=1; else count+1.
  - Ping-pong, dir down: if count==0 then dir<=up, count<=1 (0 if LIMIT==0), tc=1; else count-1.
  - One-shot: as up-wrap, except that on reaching LIMIT count holds at LIMIT, tc=1 and run clears to 0 on that edge.
- LIMIT==0: count stays 0 and tc fires every tick. In one-shot, tc fires once and the counter stops.
- Config writes:
  - Accepted regardless of ena and run; take effect next cycle.
  - Writing mode sets dir=up and leaves count unchanged.
  - Lowering LIMIT below the current count takes effect at the next tick per the rules above; no immediate jump.
- clr command:
  - Sets count=0 (LIMIT in mode 1), pcnt=0, dir=up, tc=0.
  - Other fields written in the same CTRL write also apply.
  - clr beats a coincident tick.
- Arithmetic wraps modulo 2^WIDTH; no other overflow path exists because compares use >=.

Test Plan:
- Reset, then write LIMIT=5 (addr2=0x05, addr3=0), CTRL=0x04 -> count 0,1,2,3,4,5,0 on successive cycles; tc=1 only in the cycle count returns to 0.
- PRESCALE=3, mode 0, LIMIT=0xFF -> count increments once every 4 cycles; running=1; toggling ena low for 10 cycles freezes count and pcnt.
- Mode 2, LIMIT=3 -> count sequence 0,1,2,3,2,1,0,1; tc high as count reaches 2 after 3 and as count reaches 1 after 0.
- Mode 3, LIMIT=4, run=1 -> count reaches 4, a single tc pulse, running drops the same edge, count holds 4 for 20 cycles; CTRL read returns 0x03.
- Mode 1, LIMIT=2, then write CTRL=0x0D (clr+run+mode1) coincident with a tick -> count=2, no tc; next sequence 1,0,2 with tc on 0->2.
- Run mode 0 to count=9, assert rst_n low for 1 cycle while cfg_we writes LIMIT -> count=0, tc=0, LIMIT reads 0xFF, running=0.
